node_receiver: RTL
==================

# node_receiver

Serial frame receiver sitting directly downstream of `node` on the shared single-wire `bus`. It samples one bit per clock, detects the start of a frame, deserializes header, 64-bit payload and 4-bit CRC, and checks the CRC against the same polynomial `node` uses. Frames addressed to this station, or broadcast, are presented as a parallel word with a one-cycle valid strobe. All other frames are consumed and dropped.

## Interface
- `BCAST_ADDR`, default 4'hF: destination address accepted by every receiver.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `bus`  in  1: shared serial line. Logic 0 reads as 0; 1, z and x all read as 1 (idle/pull-up).
- `addr`  in  4: this station's address; latched at the start bit.
- `crc`  in  4: CRC-4 polynomial low terms (x^4 implicit); latched at the start bit.
- `rx_valid`  out  1: one-cycle pulse when an accepted frame passes all checks.
- `rx_data`  out  64: payload of the last accepted frame.
- `rx_src`  out  4: sender address of the last accepted frame.
- `rx_mod`  out  2: `mod` field of the last accepted frame.
- `crc_err`  out  1: one-cycle pulse when an address-matched frame has a CRC mismatch.
- `frame_err`  out  1: one-cycle pulse when the stop bit reads as 0.
- `busy`  out  1: high from the cycle after the start bit through the stop-bit cycle.

## Operation
- Frame format, one bit per clock, MSB first, 80 bits in total:
  - start (0)
  - dest[3:0]
  - src[3:0]
  - mod[1:0]
  - data[63:0]
  - crc[3:0]
  - stop (1)
- States: IDLE → HDR (10 bits) → DATA (64 bits) → CRCF (4 bits) → STOP (1 bit) → IDLE. A 7-bit bit counter is reloaded on every state entry.
- IDLE: a sampled 0 on `bus` is the start bit. On that edge:
  - latch `addr` and `crc`
  - clear the CRC register to 4'h0
  - enter HDR
- Serial CRC, updated for every bit in HDR and DATA (74 bits):
  - fb = bit ^ r[3]
  - r ← {r[2:0],1'b0} ^ (fb ? crc_latched : 4'h0)
- CRCF: the 4 received bits are shifted into a compare register. The CRC register is frozen.
- STOP evaluation, performed in priority order:
  - Stop bit = 0: pulse `frame_err`; no other pulse.
  - Else, dest ≠ latched addr and dest ≠ BCAST_ADDR: no pulse (frame dropped silently).
  - Else, received CRC ≠ computed r: pulse `crc_err`.
  - Else: update `rx_data`, `rx_src` and `rx_mod`, and pulse `rx_valid`.
- After STOP the block always returns to IDLE. It does not resynchronize mid-frame.
- `rx_data`, `rx_src` and `rx_mod` hold their values until the next accepted frame. A rejected frame never alters them.
- The bit immediately after the stop bit may be a new start bit: back-to-back frames with zero idle gap are supported.

## Timing
- Cycle 0 is the edge at which the start bit is sampled.
- Sample positions: dest at cycles 1–4, src at 5–8, mod at 9–10, data at 11–74, CRC at 75–78, stop at 79.
- `rx_valid`, `crc_err` and `frame_err` are registered and are high for exactly the cycle after edge 79 (edge 80). Latency is 80 clocks from start bit to strobe.
- `busy` is high during cycles 1–79.
- Reset values: all outputs are 0, the state is IDLE, and the latched addr, poly and CRC are 0.
- Reset asserted mid-frame: the block returns to IDLE at the next edge, all outputs clear, and no strobe is issued for the aborted frame.
- While reset is high, `bus` activity is ignored. A start bit present on the first edge after reset deasserts is accepted.
- Changes to `addr` or `crc` during a frame do not affect that frame.

## Test plan
- Frame dest=1, src=0, mod=1, data=64'h1, poly=4'b0011, correct CRC (from the bench LFSR model); receiver addr=1 → `rx_valid` pulse at cycle 80, `rx_data`=64'h1, `rx_src`=0, `rx_mod`=1, no error pulse.
- Same frame with receiver addr=2 → no pulse, outputs unchanged; the same frame with dest=4'hF → accepted on addr=2.
- Same frame with data bit 0 flipped after CRC generation → `crc_err` pulse at cycle 80; `rx_data` keeps its previous value.
- Stop bit driven 0 → `frame_err` only, even with a valid CRC; the next frame is received correctly.
- Two valid frames back-to-back with no idle gap (data=64'hDEADBEEF_00000001, then 64'hFFFF_FFFF_FFFF_FFFF) → two `rx_valid` pulses 80 cycles apart with the correct data each.
- Reset pulsed at cycle 40 of a frame → outputs 0 and no strobe for that frame. `bus` held at z afterwards → stays IDLE with `busy`=0.

Source files
------------

// File: rtl/node_receiver.sv
// Serial frame receiver for the single-wire node bus: deserializes 80-bit frames,
// checks the CRC-4 and presents accepted frames with a one-cycle strobe.
module node_receiver #(
    parameter logic [3:0] BCAST_ADDR = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus,
    input  logic [3:0]  addr,
    input  logic [3:0]  crc,
    output logic        rx_valid,
    output logic [63:0] rx_data,
    output logic [3:0]  rx_src,
    output logic [1:0]  rx_mod,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CRCF, STOP} state_t;

    state_t      state, state_next;
    logic [6:0]  cnt, cnt_next;
    logic        bit_in;
    logic        start;
    logic        addr_hit;
    logic        crc_ok;
    logic [3:0]  addr_l;
    logic [3:0]  poly_l;
    logic [3:0]  crc_r;
    logic [3:0]  crc_rx;
    logic [9:0]  hdr_sr;
    logic [63:0] data_sr;

    function automatic logic [3:0] crc_step(input logic [3:0] r, input logic [3:0] poly,
                                            input logic b);
        logic fb;
        fb = b ^ r[3];
        return {r[2:0], 1'b0} ^ (fb ? poly : 4'h0);
    endfunction

    // Only a driven 0 is a zero; undriven (z) or unknown levels read as the idle 1.
    always_comb begin
        case (bus)
            1'b0:    bit_in = 1'b0;
            default: bit_in = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt - 7'd1;
        start      = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 7'd9;
                if (!bit_in) begin
                    start      = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (cnt == 7'd0) begin
                    state_next = DATA;
                    cnt_next   = 7'd63;
                end
            end
            DATA: begin
                if (cnt == 7'd0) begin
                    state_next = CRCF;
                    cnt_next   = 7'd3;
                end
            end
            CRCF: begin
                if (cnt == 7'd0) begin
                    state_next = STOP;
                    cnt_next   = 7'd0;
                end
            end
            STOP: begin
                state_next = IDLE;
                cnt_next   = 7'd9;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 7'd9;
            end
        endcase
    end

    assign addr_hit = (hdr_sr[9:6] == addr_l) || (hdr_sr[9:6] == BCAST_ADDR);
    assign crc_ok   = (crc_rx == crc_r);
    assign busy     = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 7'd0;
            addr_l    <= 4'h0;
            poly_l    <= 4'h0;
            crc_r     <= 4'h0;
            rx_valid  <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= 64'h0;
            rx_src    <= 4'h0;
            rx_mod    <= 2'h0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rx_valid  <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                addr_l <= addr;
                poly_l <= crc;
                crc_r  <= 4'h0;
            end else if (state == HDR || state == DATA) begin
                crc_r <= crc_step(crc_r, poly_l, bit_in);
            end
            // Stop-bit cycle: framing error outranks address filtering, which outranks CRC.
            if (state == STOP) begin
                if (!bit_in) begin
                    frame_err <= 1'b1;
                end else if (addr_hit) begin
                    if (!crc_ok) begin
                        crc_err <= 1'b1;
                    end else begin
                        rx_valid <= 1'b1;
                        rx_data  <= data_sr;
                        rx_src   <= hdr_sr[5:2];
                        rx_mod   <= hdr_sr[1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == HDR) begin
            hdr_sr <= {hdr_sr[8:0], bit_in};
        end
        if (state == DATA) begin
            data_sr <= {data_sr[62:0], bit_in};
        end
        if (state == CRCF) begin
            crc_rx <= {crc_rx[2:0], bit_in};
        end
    end

endmodule
